// File: rtl/board_pkg.sv
// Board-wide timing constants and the per-key FSM state shared by the key front end.
package board_pkg;

  localparam int CLK_HZ       = 50_000_000;
  localparam int DEB_20MS     = CLK_HZ / 50;
  localparam int HOLD_500MS   = CLK_HZ / 2;
  localparam int REPEAT_100MS = CLK_HZ / 10;

  typedef enum logic [1:0] {
    KEY_RELEASED = 2'd0,
    KEY_HOLD     = 2'd1,
    KEY_REPEAT   = 2'd2
  } key_state_e;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-flop synchroniser, debounce counter, hold/repeat FSM and
// registered level/press/release/repeat strobes.
module key_chan
  import board_pkg::*;
#(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int DEB_CYCLES    = DEB_20MS,
  parameter int HOLD_CYCLES   = HOLD_500MS,
  parameter int REPEAT_CYCLES = REPEAT_100MS,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int DEB_W  = cnt_w(DEB_CYCLES);
  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int PER_W  = cnt_w(REPEAT_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PER_W-1:0]  PER_MAX  = PER_W'(REPEAT_CYCLES - 1);
  localparam logic IDLE_LVL = ACTIVE_LOW;

  logic sync1_q, sync2_q, sample;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic level_q, level_d, rise, fall;
  logic press_q, press_d, release_q, release_d, repeat_q, repeat_d;
  key_state_e state_q, state_d;

  assign sample = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Counter only advances while the sample disagrees with the accepted level.
  always_comb begin
    deb_d   = '0;
    level_d = level_q;
    if (sample != level_q) begin
      if (deb_q == DEB_MAX) level_d = ~level_q;
      else                  deb_d   = deb_q + DEB_W'(1);
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= IDLE_LVL;
      sync2_q   <= IDLE_LVL;
      deb_q     <= '0;
      level_q   <= 1'b0;
      state_q   <= KEY_RELEASED;
      hold_q    <= '0;
      per_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= key_i;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      level_q   <= level_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      per_q     <= per_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    per_d   = per_q;
    case (state_q)
      KEY_RELEASED: begin
        hold_d = '0;
        per_d  = '0;
        if (rise) state_d = KEY_HOLD;
      end
      KEY_HOLD: begin
        if (fall) begin
          state_d = KEY_RELEASED;
          hold_d  = '0;
        end else if (hold_q == HOLD_MAX) begin
          // With repeat disabled the counter parks here and the key stays in HOLD.
          if (REPEAT_EN) begin
            state_d = KEY_REPEAT;
            hold_d  = '0;
            per_d   = '0;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      KEY_REPEAT: begin
        if (fall) begin
          state_d = KEY_RELEASED;
          per_d   = '0;
        end else if (per_q == PER_MAX) begin
          per_d = '0;
        end else begin
          per_d = per_q + PER_W'(1);
        end
      end
      default: begin
        state_d = KEY_RELEASED;
        hold_d  = '0;
        per_d   = '0;
      end
    endcase
  end

  always_comb begin
    press_d   = rise;
    release_d = fall;
    repeat_d  = rise
              | (state_q == KEY_HOLD && state_d == KEY_REPEAT)
              | (state_q == KEY_REPEAT && state_d == KEY_REPEAT && per_q == PER_MAX);
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_bank.sv
// N-channel push-button front end: one key_chan per key plus an any-key flag.
module key_bank
  import board_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int DEB_CYCLES    = DEB_20MS,
  parameter int HOLD_CYCLES   = HOLD_500MS,
  parameter int REPEAT_CYCLES = REPEAT_100MS,
  parameter logic [N_KEYS-1:0] REPEAT_EN = {N_KEYS{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              any_pressed
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_chan #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .DEB_CYCLES   (DEB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN    (REPEAT_EN[i])
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .key_i    (key_in[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .repeat_o (key_repeat[i])
    );
  end

  assign any_pressed = |key_level;

endmodule

// File: tb/tb_key_bank.sv
// Directed bench for key_bank with short debounce/hold/repeat timings.
module tb_key_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_in = 4'hF;
  logic [3:0] key_level, key_press, key_release, key_repeat;
  logic       any_pressed;
  logic [16:0] obs, exp_v;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_bank #(
    .N_KEYS(4), .ACTIVE_LOW(1'b1), .DEB_CYCLES(4), .HOLD_CYCLES(10),
    .REPEAT_CYCLES(3), .REPEAT_EN(4'b0111)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .key_repeat(key_repeat),
    .any_pressed(any_pressed)
  );

  // {level, press, release, repeat, any}
  assign obs = {key_level, key_press, key_release, key_repeat, any_pressed};

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    step(2);
    n_vec++;
    if (obs !== 17'd0) begin n_err++; $display("FAIL reset_held: got %b want %b", obs, 17'd0); end
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      n_vec++;
      if (obs !== 17'd0) begin n_err++; $display("FAIL reset_idle cyc %0d: got %b want %b", i, obs, 17'd0); end
    end
  endtask

  task automatic test_clean_press;
    key_in[0] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      exp_v = (i == 6) ? {4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1} :
              (i == 7) ? {4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1} : 17'd0;
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL clean_press cyc %0d: got %b want %b", i, obs, exp_v); end
    end
    key_in[0] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      exp_v = (i < 6)  ? {4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1} :
              (i == 6) ? {4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0} : 17'd0;
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL clean_release cyc %0d: got %b want %b", i, obs, exp_v); end
    end
  endtask

  task automatic test_bounce;
    for (int r = 0; r < 5; r++) begin
      key_in[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        step(1);
        n_vec++;
        if (obs !== 17'd0) begin n_err++; $display("FAIL bounce_low r%0d c%0d: got %b want %b", r, i, obs, 17'd0); end
      end
      key_in[1] = 1'b1;
      step(1);
      n_vec++;
      if (obs !== 17'd0) begin n_err++; $display("FAIL bounce_high r%0d: got %b want %b", r, obs, 17'd0); end
    end
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_vec++;
      if (obs !== 17'd0) begin n_err++; $display("FAIL bounce_settle c%0d: got %b want %b", i, obs, 17'd0); end
    end
  endtask

  task automatic test_auto_repeat;
    logic rep;
    key_in[2] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      exp_v = (i == 6) ? {4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1} : 17'd0;
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL repeat_press cyc %0d: got %b want %b", i, obs, exp_v); end
    end
    for (int k = 1; k <= 25; k++) begin
      step(1);
      rep = (k >= 10) && ((k - 10) % 3 == 0);
      exp_v = {4'b0100, 4'b0000, 4'b0000, rep ? 4'b0100 : 4'b0000, 1'b1};
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL repeat_hold +%0d: got %b want %b", k, obs, exp_v); end
    end
    key_in[2] = 1'b1;
    for (int k = 26; k <= 33; k++) begin
      step(1);
      exp_v = (k < 31)  ? {4'b0100, 4'b0000, 4'b0000, (k == 28) ? 4'b0100 : 4'b0000, 1'b1} :
              (k == 31) ? {4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0} : 17'd0;
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL repeat_release +%0d: got %b want %b", k, obs, exp_v); end
    end
  endtask

  task automatic test_repeat_disabled;
    key_in[3] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      exp_v = (i == 6) ? {4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1} : 17'd0;
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL norep_press cyc %0d: got %b want %b", i, obs, exp_v); end
    end
    for (int k = 1; k <= 30; k++) begin
      step(1);
      exp_v = {4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b1};
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL norep_hold +%0d: got %b want %b", k, obs, exp_v); end
    end
    key_in[3] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      exp_v = (i < 6)  ? {4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b1} :
              (i == 6) ? {4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b0} : 17'd0;
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL norep_release cyc %0d: got %b want %b", i, obs, exp_v); end
    end
  endtask

  task automatic test_back_to_back;
    key_in = 4'b1010;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      exp_v = (i == 6) ? {4'b0101, 4'b0101, 4'b0000, 4'b0101, 1'b1} : 17'd0;
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL simul_press cyc %0d: got %b want %b", i, obs, exp_v); end
    end
    key_in[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      exp_v = (i < 6) ? {4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b1} :
                        {4'b0100, 4'b0000, 4'b0001, 4'b0000, 1'b1};
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL simul_rel0 cyc %0d: got %b want %b", i, obs, exp_v); end
    end
    key_in[2] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      exp_v = (i < 6)  ? {4'b0100, 4'b0000, 4'b0000, (i == 4) ? 4'b0100 : 4'b0000, 1'b1} :
              (i == 6) ? {4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0} : 17'd0;
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL simul_rel2 cyc %0d: got %b want %b", i, obs, exp_v); end
    end
  endtask

  task automatic test_reset_mid;
    key_in[0] = 1'b0;
    step(6);
    exp_v = {4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rstmid_press: got %b want %b", obs, exp_v); end
    step(12);
    exp_v = {4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL rstmid_repeat_state: got %b want %b", obs, exp_v); end
    reset = 1'b1;
    #1;
    n_vec++;
    if (obs !== 17'd0) begin n_err++; $display("FAIL rstmid_async: got %b want %b", obs, 17'd0); end
    step(3);
    n_vec++;
    if (obs !== 17'd0) begin n_err++; $display("FAIL rstmid_held: got %b want %b", obs, 17'd0); end
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      exp_v = (i == 6) ? {4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1} : 17'd0;
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL rstmid_repress cyc %0d: got %b want %b", i, obs, exp_v); end
    end
    key_in[0] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      exp_v = (i < 6)  ? {4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1} :
              (i == 6) ? {4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0} : 17'd0;
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL rstmid_release cyc %0d: got %b want %b", i, obs, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_repeat_disabled();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
